rosc_timer_reader: RTL and testbench

System-clock-domain controller and reader for the NAND ring-oscillator timer. On a request it drives clear, start and stop to the timer to open a measurement window of a programmed number of system clocks. It then safely transfers the timer's 32-bit elapsed count across the clock boundary and presents it with a valid/ready handshake. It sits between the register/host logic and the free-running oscillator timer.

---
 rtl/rosc_timer_pkg.sv | 19 +
 rtl/rosc_count_sync.sv | 27 ++
 rtl/rosc_timer_reader.sv | 169 ++++++++++++++++
 tb/tb_rosc_timer_reader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rosc_timer_pkg.sv
// rosc_timer_pkg: shared types and constants for the
// ring-oscillator timer reader.
package rosc_timer_pkg;

  localparam int COUNT_W     = 32;
  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_START  = 3'd2,
    ST_RUN    = 3'd3,
    ST_STOP   = 3'd4,
    ST_SYNC   = 3'd5,
    ST_SAMPLE = 3'd6,
    ST_DONE   = 3'd7
  } state_e;

endpackage

// File: rtl/rosc_count_sync.sv
// rosc_count_sync: per-bit multi-flop synchroniser for the
// oscillator count, plus a one-cycle history for stability checks.
module rosc_count_sync
  import rosc_timer_pkg::*;
(
  input  logic               clk,
  input  logic [COUNT_W-1:0] din,
  output logic [COUNT_W-1:0] dout,
  output logic               stable
);

  logic [SYNC_STAGES-1:0][COUNT_W-1:0] stg;
  logic [COUNT_W-1:0]                  prev;

  // Free-running with no reset so the chain keeps tracking the timer.
  always_ff @(posedge clk) begin
    stg[0] <= din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      stg[i] <= stg[i-1];
    end
    prev <= stg[SYNC_STAGES-1];
  end

  assign dout   = stg[SYNC_STAGES-1];
  assign stable = (stg[SYNC_STAGES-1] == prev);

endmodule

// File: rtl/rosc_timer_reader.sv
// rosc_timer_reader: opens a timed window on the ring-oscillator
// timer and reads its count back across the clock boundary.
module rosc_timer_reader
  import rosc_timer_pkg::*;
#(
  parameter int WINDOW_W    = 16,
  parameter int HOLD_CYCLES = 4,
  parameter int SETTLE_MAX  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic [WINDOW_W-1:0] window_cycles,
  output logic                busy,
  output logic                tmr_clear,
  output logic                tmr_start,
  output logic                tmr_stop,
  input  logic [COUNT_W-1:0]  tmr_count,
  output logic [COUNT_W-1:0]  result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                error
);

  localparam int HOLD_MAX =
    (HOLD_CYCLES > SYNC_STAGES) ? HOLD_CYCLES : SYNC_STAGES;
  localparam int HW = $clog2(HOLD_MAX + 1);
  localparam int AW = $clog2(SETTLE_MAX + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] SYNC_LAST = HW'(SYNC_STAGES - 1);
  localparam logic [AW-1:0] ATT_LAST  = AW'(SETTLE_MAX - 1);
  localparam logic [WINDOW_W-1:0] WIN_ONE = WINDOW_W'(1);

  state_e              state;
  state_e              state_nxt;
  logic [HW-1:0]       hold_cnt;
  logic [HW-1:0]       hold_nxt;
  logic [WINDOW_W-1:0] win_cnt;
  logic [WINDOW_W-1:0] win_nxt;
  logic [AW-1:0]       att_cnt;
  logic [AW-1:0]       att_nxt;
  logic [COUNT_W-1:0]  res_nxt;
  logic                err_nxt;
  logic [COUNT_W-1:0]  sync_q;
  logic                sync_eq;
  logic                hold_last;

  rosc_count_sync u_sync (
    .clk    (clk),
    .din    (tmr_count),
    .dout   (sync_q),
    .stable (sync_eq)
  );

  assign hold_last = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    win_nxt   = win_cnt;
    att_nxt   = att_cnt;
    res_nxt   = result;
    err_nxt   = error;
    unique case (state)
      ST_IDLE: begin
        if (go && (window_cycles != '0)) begin
          state_nxt = ST_CLEAR;
          win_nxt   = window_cycles;
          hold_nxt  = '0;
        end
      end
      ST_CLEAR: begin
        if (hold_last) begin
          state_nxt = ST_START;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_START: begin
        if (hold_last) begin
          state_nxt = ST_RUN;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_RUN: begin
        if (win_cnt == WIN_ONE) begin
          state_nxt = ST_STOP;
          hold_nxt  = '0;
        end else begin
          win_nxt = win_cnt - WIN_ONE;
        end
      end
      ST_STOP: begin
        if (hold_last) begin
          state_nxt = ST_SYNC;
          hold_nxt  = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_SYNC: begin
        if (hold_cnt == SYNC_LAST) begin
          state_nxt = ST_SAMPLE;
          hold_nxt  = '0;
          att_nxt   = '0;
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      ST_SAMPLE: begin
        // Two matching reads in a row mean no bit was mid-flight.
        if (sync_eq) begin
          state_nxt = ST_DONE;
          res_nxt   = sync_q;
          err_nxt   = 1'b0;
        end else if (att_cnt == ATT_LAST) begin
          state_nxt = ST_DONE;
          res_nxt   = sync_q;
          err_nxt   = 1'b1;
        end else begin
          att_nxt = att_cnt + AW'(1);
        end
      end
      ST_DONE: begin
        if (result_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so they toggle on the
  // same edge as the state register and never glitch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      hold_cnt     <= '0;
      win_cnt      <= '0;
      att_cnt      <= '0;
      busy         <= 1'b0;
      tmr_clear    <= 1'b0;
      tmr_start    <= 1'b0;
      tmr_stop     <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      error        <= 1'b0;
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      win_cnt      <= win_nxt;
      att_cnt      <= att_nxt;
      busy         <= (state_nxt != ST_IDLE);
      tmr_clear    <= (state_nxt == ST_CLEAR);
      tmr_start    <= (state_nxt == ST_START);
      tmr_stop     <= (state_nxt == ST_STOP);
      result_valid <= (state_nxt == ST_DONE);
      result       <= res_nxt;
      error        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_rosc_timer_reader.sv
// tb_rosc_timer_reader: directed bench with a cycle-schedule model
// of the reader and a behavioural ring-oscillator timer.
module tb_rosc_timer_reader;

  localparam int H  = 4;
  localparam int SM = 8;

  logic        clk;
  logic        rst_n;
  logic        go;
  logic [15:0] window_cycles;
  logic        busy;
  logic        tmr_clear;
  logic        tmr_start;
  logic        tmr_stop;
  logic [31:0] tmr_count;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ready;
  logic        error;

  rosc_timer_reader #(
    .WINDOW_W    (16),
    .HOLD_CYCLES (H),
    .SETTLE_MAX  (SM)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .window_cycles (window_cycles),
    .busy          (busy),
    .tmr_clear     (tmr_clear),
    .tmr_start     (tmr_start),
    .tmr_stop      (tmr_stop),
    .tmr_count     (tmr_count),
    .result        (result),
    .result_valid  (result_valid),
    .result_ready  (result_ready),
    .error         (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errs   = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Timer: clear zeroes, start runs, after stop it emits the final
  // value, optionally preceded by a burst of alternating values.
  logic [31:0] tm_final   = '0;
  int          tm_toggles = 0;
  logic [31:0] tm_val     = '0;
  bit          tm_run     = 1'b0;
  bit          tm_stopped = 1'b0;
  int          tm_k       = 0;

  always @(negedge clk) begin
    if (tmr_clear) begin
      tm_run = 1'b0; tm_stopped = 1'b0; tm_val = '0;
    end else if (tmr_start) begin
      tm_run = 1'b1;
    end else if (tmr_stop && !tm_stopped) begin
      tm_run = 1'b0; tm_stopped = 1'b1; tm_k = 0;
    end
    if (tm_run) tm_val = tm_val + 32'd7;
    if (tm_stopped) begin
      if (tm_k < tm_toggles && ((tm_toggles - tm_k) % 2 == 1))
        tm_val = ~tm_final;
      else
        tm_val = tm_final;
      tm_k++;
    end
    tmr_count = tm_val;
  end

  // Model: phase 0 idle, 1 measuring, 2 result pending. mr is the
  // cycle number (go-accept cycle = 0) of the cycle about to begin.
  int          ph = 0;
  int          mr = 0;
  int          mw = 0;
  int          mcyc = 0;
  logic [31:0] hist [4];
  logic [31:0] e_res = '0;
  logic        e_err = 1'b0;
  logic e_busy, e_clr, e_sta, e_stp, e_val;

  function automatic logic [31:0] past(input int k);
    return hist[(mcyc - k) & 3];
  endfunction

  always @(posedge clk) begin
    int s0;
    mcyc++;
    hist[mcyc & 3] = tmr_count;
    if (!rst_n) begin
      ph = 0; e_res = '0; e_err = 1'b0;
    end else begin
      case (ph)
        0: if (go && window_cycles != 0) begin
             mw = int'(window_cycles); mr = 1; ph = 1;
           end
        1: begin
             s0 = 3*H + mw + 3;
             // Synchronised view lags 2 cycles; compare with 1 before.
             if (mr >= s0) begin
               if (past(2) == past(3)) begin
                 e_res = past(2); e_err = 1'b0; ph = 2;
               end else if (mr - s0 == SM - 1) begin
                 e_res = past(2); e_err = 1'b1; ph = 2;
               end
             end
             mr++;
           end
        default: if (result_ready) ph = 0;
      endcase
    end
    e_busy = (ph != 0);
    e_val  = (ph == 2);
    e_clr  = (ph == 1) && mr >= 1 && mr <= H;
    e_sta  = (ph == 1) && mr >= H+1 && mr <= 2*H;
    e_stp  = (ph == 1) && mr >= 2*H+mw+1 && mr <= 3*H+mw;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(e_busy));
      chk("tmr_clear", 32'(tmr_clear), 32'(e_clr));
      chk("tmr_start", 32'(tmr_start), 32'(e_sta));
      chk("tmr_stop", 32'(tmr_stop), 32'(e_stp));
      chk("one_pulse",
          32'($countones({tmr_clear, tmr_start, tmr_stop}) <= 1), 32'd1);
      chk("result_valid", 32'(result_valid), 32'(e_val));
      if (e_val) begin
        chk("result", result, e_res);
        chk("error", 32'(error), 32'(e_err));
      end
    end
  end

  // Issue go on a negedge; returns at the negedge of the first
  // result_valid cycle with hand-computed latency/result/error checked.
  task automatic measure(input logic [15:0] w, input logic [31:0] f,
                         input int t, input logic rdy,
                         input int exp_lat, input logic [31:0] exp_res,
                         input logic exp_err);
    int n;
    tm_final = f; tm_toggles = t;
    go = 1'b1; window_cycles = w; result_ready = rdy;
    @(negedge clk);
    go = 1'b0;
    n = 1;
    while (!result_valid && n < exp_lat + 50) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(exp_lat));
    chk("lit_result", result, exp_res);
    chk("lit_error", 32'(error), 32'(exp_err));
  endtask

  initial begin
    rst_n = 1'b0; go = 1'b0; window_cycles = '0;
    result_ready = 1'b0; tmr_count = '0;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(result_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_ctrl", 32'({tmr_clear, tmr_start, tmr_stop}), 32'd0);
    rst_n = 1'b1;

    // go with zero window is ignored
    go = 1'b1; window_cycles = '0;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
    chk("zero_win_busy", 32'(busy), 32'd0);

    // nominal with backpressure
    measure(16'd100, 32'h0000_1234, 0, 1'b0, 116, 32'h0000_1234, 1'b0);
    for (int i = 0; i < 20; i++) begin
      go = i[0]; window_cycles = 16'd5;
      @(negedge clk);
      chk("bp_valid", 32'(result_valid), 32'd1);
      chk("bp_result", result, 32'h0000_1234);
    end
    go = 1'b1; result_ready = 1'b1;
    @(negedge clk);
    go = 1'b0;
    chk("bp_exit_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("bp_go_ignored", 32'(busy), 32'd0);

    // count never settles, then settles after three attempts
    measure(16'd10, 32'hA5A5_0F0F, 1000, 1'b1, 33, 32'h5A5A_F0F0, 1'b1);
    @(negedge clk);
    measure(16'd10, 32'hA5A5_0F0F, 6, 1'b1, 29, 32'hA5A5_0F0F, 1'b0);
    @(negedge clk);

    // reset during RUN
    tm_final = 32'hDEAD_0001; tm_toggles = 0;
    go = 1'b1; window_cycles = 16'd100;
    @(negedge clk);
    go = 1'b0;
    repeat (30) @(negedge clk);
    chk("run_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ctrl", 32'({tmr_clear, tmr_start, tmr_stop}), 32'd0);
    measure(16'd20, 32'h0BAD_CAFE, 0, 1'b1, 36, 32'h0BAD_CAFE, 1'b0);
    @(negedge clk);

    // back-to-back, ready tied high
    measure(16'd1, 32'h0000_0011, 0, 1'b1, 17, 32'h0000_0011, 1'b0);
    @(negedge clk);
    measure(16'hFFFF, 32'h8765_4321, 0, 1'b1, 65551,
            32'h8765_4321, 1'b0);
    @(negedge clk);
    chk("end_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
